hazard_stall_ctrl: RTL and testbench

- Pipeline hazard scheduler for the 5-stage CPU.
- Sits beside the forwarding unit and handles the hazards forwarding cannot resolve:
  - load-use: stall one cycle;
  - multi-cycle mult/div occupancy of HI/LO: stall dependent instructions until done;
  - taken branch resolved in EX: flush IF/ID and ID/EX.
- Drives the PC and IF/ID write enables, the IF/ID and ID/EX flush controls, and a stall-cycle performance counter.

---
 rtl/hazard_stall_ctrl.sv | 112 +++++++++++
 tb/tb_hazard_stall_ctrl.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_stall_ctrl.sv
// Hazard scheduler for the 5-stage pipeline: load-use and HI/LO occupancy stalls,
// taken-branch flushes, and a saturating count of stall cycles.
module hazard_stall_ctrl #(
  parameter int unsigned MD_LATENCY = 32,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             MemRead_out_from_EX,
  input  logic [4:0]       Rt_out_from_EX,
  input  logic [4:0]       Rs_in_ID,
  input  logic [4:0]       Rt_in_ID,
  input  logic             uses_rt_in_ID,
  input  logic             muldiv_in_ID,
  input  logic             mfhilo_in_ID,
  input  logic             muldiv_start_in_EX,
  input  logic             branch_taken_in_EX,
  output logic             PCWrite,
  output logic             IF_ID_Write,
  output logic             IF_ID_Flush,
  output logic             ID_EX_Flush,
  output logic             muldiv_busy,
  output logic [CNT_W-1:0] stall_count
);

  typedef enum logic [0:0] {StIdle, StMdBusy} state_e;

  localparam logic [7:0] MdLoad = 8'(MD_LATENCY);

  state_e           state_q, state_d;
  logic [7:0]       md_cnt_q, md_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic busy;
  logic lu_hazard;
  logic md_hazard;
  logic stall;

  assign busy = (state_q == StMdBusy);

  // Register 0 is never a real destination, so it can never create a load-use hazard.
  assign lu_hazard = MemRead_out_from_EX && (Rt_out_from_EX != 5'd0) &&
                     ((Rt_out_from_EX == Rs_in_ID) ||
                      (uses_rt_in_ID && (Rt_out_from_EX == Rt_in_ID)));

  assign md_hazard = (mfhilo_in_ID || muldiv_in_ID) && (busy || muldiv_start_in_EX);

  // A taken branch squashes the instruction that would have stalled.
  assign stall = (lu_hazard || md_hazard) && !branch_taken_in_EX;

  always_comb begin
    state_d  = state_q;
    md_cnt_d = md_cnt_q;
    case (state_q)
      StIdle: begin
        if (muldiv_start_in_EX) begin
          state_d  = StMdBusy;
          md_cnt_d = MdLoad;
        end
      end
      StMdBusy: begin
        // A start seen here is ignored; the occupancy is never restarted.
        if (md_cnt_q == 8'd1) begin
          state_d  = StIdle;
          md_cnt_d = 8'd0;
        end else begin
          md_cnt_d = md_cnt_q - 8'd1;
        end
      end
    endcase
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  always_comb begin
    PCWrite     = 1'b1;
    IF_ID_Write = 1'b1;
    IF_ID_Flush = 1'b0;
    ID_EX_Flush = 1'b0;
    muldiv_busy = busy;
    if (rst) begin
      muldiv_busy = 1'b0;
    end else if (branch_taken_in_EX) begin
      IF_ID_Flush = 1'b1;
      ID_EX_Flush = 1'b1;
    end else if (stall) begin
      PCWrite     = 1'b0;
      IF_ID_Write = 1'b0;
      ID_EX_Flush = 1'b1;
    end
  end

  assign stall_count = stall_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      md_cnt_q    <= 8'd0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      md_cnt_q    <= md_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Randomized self-checking bench for hazard_stall_ctrl against a cycle-level
// behavioural model, plus directed scenarios with literal expectations.
module tb_hazard_stall_ctrl;

  localparam int MdLat  = 4;
  localparam int CntW   = 4;
  localparam int CntMax = (1 << CntW) - 1;

  logic            clk = 1'b0;
  logic            rst;
  logic            mem_read;
  logic [4:0]      rt_ex;
  logic [4:0]      rs_id;
  logic [4:0]      rt_id;
  logic            uses_rt;
  logic            muldiv_id;
  logic            mfhilo_id;
  logic            md_start;
  logic            br_taken;
  logic            pc_write;
  logic            if_id_write;
  logic            if_id_flush;
  logic            id_ex_flush;
  logic            md_busy;
  logic [CntW-1:0] stall_count;

  int tests_run = 0;
  int tests_failed = 0;
  bit check_en = 1'b0;

  // Model state: cycles of mult/div occupancy left, and the stall count.
  int m_rem = 0;
  int m_cnt = 0;

  hazard_stall_ctrl #(
    .MD_LATENCY(MdLat),
    .CNT_W     (CntW)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .MemRead_out_from_EX(mem_read),
    .Rt_out_from_EX     (rt_ex),
    .Rs_in_ID           (rs_id),
    .Rt_in_ID           (rt_id),
    .uses_rt_in_ID      (uses_rt),
    .muldiv_in_ID       (muldiv_id),
    .mfhilo_in_ID       (mfhilo_id),
    .muldiv_start_in_EX (md_start),
    .branch_taken_in_EX (br_taken),
    .PCWrite            (pc_write),
    .IF_ID_Write        (if_id_write),
    .IF_ID_Flush        (if_id_flush),
    .ID_EX_Flush        (id_ex_flush),
    .muldiv_busy        (md_busy),
    .stall_count        (stall_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    tests_run++;
    if (act != exp) begin
      tests_failed++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  // Compare against the model mid-cycle, then advance the model across the next edge.
  always @(negedge clk) begin
    if (check_en) begin
      bit busy, lu, md, stall;
      int e_pc, e_ifw, e_iff, e_idf, e_busy;
      busy  = (m_rem > 0);
      lu    = mem_read && (rt_ex != 0) &&
              ((rt_ex == rs_id) || (uses_rt && (rt_ex == rt_id)));
      md    = (mfhilo_id || muldiv_id) && (busy || md_start);
      stall = (lu || md) && !br_taken;
      if (rst) begin
        e_pc = 1; e_ifw = 1; e_iff = 0; e_idf = 0; e_busy = 0;
      end else begin
        e_busy = busy ? 1 : 0;
        e_pc   = stall ? 0 : 1;
        e_ifw  = stall ? 0 : 1;
        e_iff  = br_taken ? 1 : 0;
        e_idf  = (br_taken || stall) ? 1 : 0;
      end
      check("PCWrite", int'(pc_write), e_pc);
      check("IF_ID_Write", int'(if_id_write), e_ifw);
      check("IF_ID_Flush", int'(if_id_flush), e_iff);
      check("ID_EX_Flush", int'(id_ex_flush), e_idf);
      check("muldiv_busy", int'(md_busy), e_busy);
      check("stall_count", int'(stall_count), m_cnt);
      if (rst) begin
        m_rem = 0;
        m_cnt = 0;
      end else begin
        if (m_rem > 0) m_rem = m_rem - 1;
        else if (md_start) m_rem = MdLat;
        if (stall && m_cnt < CntMax) m_cnt = m_cnt + 1;
      end
    end
  end

  task automatic idle_inputs();
    mem_read = 0; rt_ex = 0; rs_id = 0; rt_id = 0; uses_rt = 0;
    muldiv_id = 0; mfhilo_id = 0; md_start = 0; br_taken = 0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic mid_cycle();
    @(negedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    next_cycle();
    check_en = 1'b1;

    // Reset state
    next_cycle();
    rst = 1'b0;
    mid_cycle();
    check("rst_count", int'(stall_count), 0);
    check("rst_busy", int'(md_busy), 0);
    check("rst_pcwrite", int'(pc_write), 1);

    // Load-use on rs: one stall cycle
    next_cycle();
    mem_read = 1; rt_ex = 5; rs_id = 5;
    mid_cycle();
    check("lu_pcwrite", int'(pc_write), 0);
    check("lu_ifidw", int'(if_id_write), 0);
    check("lu_idexflush", int'(id_ex_flush), 1);
    next_cycle();
    idle_inputs();
    mid_cycle();
    check("lu_count", int'(stall_count), 1);
    check("lu_release", int'(pc_write), 1);

    // No stall: $0 destination, and rt match without rt use
    next_cycle();
    mem_read = 1; rt_ex = 0; rs_id = 0;
    mid_cycle();
    check("r0_nostall", int'(pc_write), 1);
    next_cycle();
    rt_ex = 5; rs_id = 3; rt_id = 5; uses_rt = 0;
    mid_cycle();
    check("rt_unused_nostall", int'(pc_write), 1);
    next_cycle();
    idle_inputs();
    mid_cycle();
    check("nostall_count", int'(stall_count), 1);

    // mult/div occupancy with mfhi held in ID
    for (int i = 0; i <= MdLat + 1; i++) begin
      next_cycle();
      mfhilo_id = 1;
      md_start  = (i == 0);
      mid_cycle();
      check("md_pcwrite", int'(pc_write), (i == MdLat + 1) ? 1 : 0);
      check("md_busy", int'(md_busy), (i >= 1 && i <= MdLat) ? 1 : 0);
    end
    next_cycle();
    idle_inputs();
    mid_cycle();
    check("md_count", int'(stall_count), 6);

    // Branch flush beats load-use stall
    next_cycle();
    mem_read = 1; rt_ex = 7; rs_id = 7; br_taken = 1;
    mid_cycle();
    check("br_pcwrite", int'(pc_write), 1);
    check("br_ifidw", int'(if_id_write), 1);
    check("br_ififlush", int'(if_id_flush), 1);
    check("br_idexflush", int'(id_ex_flush), 1);
    next_cycle();
    idle_inputs();
    mid_cycle();
    check("br_count", int'(stall_count), 6);

    // Reset in the middle of an occupancy
    next_cycle();
    md_start = 1;
    next_cycle();
    md_start = 0;
    mid_cycle();
    check("abort_busy_before", int'(md_busy), 1);
    next_cycle();
    rst = 1;
    mfhilo_id = 1;
    mid_cycle();
    check("abort_busy_forced", int'(md_busy), 0);
    check("abort_pc_forced", int'(pc_write), 1);
    next_cycle();
    rst = 0;
    mid_cycle();
    check("abort_busy_after", int'(md_busy), 0);
    check("abort_nostall", int'(pc_write), 1);
    check("abort_count", int'(stall_count), 0);

    // Saturation of the stall counter
    for (int i = 0; i < 20; i++) begin
      next_cycle();
      idle_inputs();
      mem_read = 1; rt_ex = 9; rt_id = 9; uses_rt = 1; rs_id = 1;
      mid_cycle();
      if (i == 15 || i == 19) check("sat_count_mid", int'(stall_count), 15);
    end
    next_cycle();
    idle_inputs();
    mid_cycle();
    check("sat_count", int'(stall_count), 15);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      next_cycle();
      rst       = ($urandom_range(0, 59) == 0);
      mem_read  = ($urandom_range(0, 2) == 0);
      rt_ex     = 5'($urandom_range(0, 3));
      rs_id     = 5'($urandom_range(0, 3));
      rt_id     = 5'($urandom_range(0, 3));
      uses_rt   = 1'($urandom_range(0, 1));
      muldiv_id = ($urandom_range(0, 4) == 0);
      mfhilo_id = ($urandom_range(0, 4) == 0);
      md_start  = ($urandom_range(0, 7) == 0);
      br_taken  = ($urandom_range(0, 6) == 0);
    end

    next_cycle();
    check_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
